paddle_emulator: RTL and testbench



---
 rtl/paddle_pkg.sv | 40 ++++
 rtl/paddle_emulator_if.sv | 28 ++
 rtl/paddle_channel.sv | 48 ++++
 rtl/paddle_emulator.sv | 122 ++++++++++++
 tb/tb_paddle_emulator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle emulator: frame geometry defaults,
// the sync-tracking state enum, the paddle line encoding and the helper
// that limits how far a target may move in one frame.
package paddle_pkg;

    localparam int DEF_V_TOTAL     = 262;
    localparam int DEF_VS_END_LINE = 257;
    localparam int SLEW_STEP       = 4;

    // A paddle line held low means "still charging": the game latches vpos.
    localparam logic PADDLE_ACTIVE = 1'b0;
    localparam logic PADDLE_IDLE   = 1'b1;

    typedef enum logic {
        WAIT_SYNC,
        RUN
    } state_t;

    // Move cur toward req by at most SLEW_STEP, done in 9 bits so the
    // result never overshoots req and never wraps outside 0..255.
    function automatic logic [7:0] slew_toward(input logic [7:0] cur,
                                               input logic [7:0] req);
        logic [8:0] c;
        logic [8:0] r;
        logic [8:0] step;
        logic [7:0] result;
        c    = {1'b0, cur};
        r    = {1'b0, req};
        step = 9'(SLEW_STEP);
        if (r > c) begin
            if ((r - c) <= step) result = req;
            else                 result = 8'(c + step);
        end else begin
            if ((c - r) <= step) result = req;
            else                 result = 8'(c - step);
        end
        return result;
    endfunction

endpackage

// File: rtl/paddle_emulator_if.sv
// Signal bundle between the game/sync-generator side and the paddle
// emulator. The master drives sync and requested positions; the
// emulator (slave) drives the paddle lines and its status outputs.
interface paddle_emulator_if;

    logic       hsync;
    logic       vsync;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       hpaddle;
    logic       vpaddle;
    logic [8:0] line;
    logic [7:0] target_x;
    logic [7:0] target_y;
    logic       synced;
    logic       frame_strobe;

    modport master (
        output hsync, vsync, pos_x, pos_y,
        input  hpaddle, vpaddle, line, target_x, target_y, synced, frame_strobe
    );

    modport slave (
        input  hsync, vsync, pos_x, pos_y,
        output hpaddle, vpaddle, line, target_x, target_y, synced, frame_strobe
    );

endinterface

// File: rtl/paddle_channel.sv
// One paddle axis: latches the per-frame target and drives the paddle
// line low while the upcoming line index is at or below that target.
// With PADDLE_SLEW_EN defined the target creeps toward the requested
// position by a bounded step each frame instead of jumping to it.
module paddle_channel
    import paddle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [8:0] line_next,
    input  logic [7:0] pos,
    output logic [7:0] target,
    output logic       paddle
);

    logic [7:0] target_new;
    logic [7:0] target_cmp;

    // Pick the value the target takes at frame start, and the target the
    // compare should use this cycle (the fresh one when it is being loaded).
    always_comb begin
`ifdef PADDLE_SLEW_EN
        target_new = slew_toward(target, pos);
`else
        target_new = pos;
`endif
        target_cmp = load ? target_new : target;
    end

    // Target latch plus the registered line-vs-target compare; lines of
    // 256 and above can never be <= an 8-bit target, so they stay idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target <= 8'd0;
            paddle <= PADDLE_IDLE;
        end else begin
            if (load) begin
                target <= target_new;
            end
            if (load || step) begin
                paddle <= (line_next <= {1'b0, target_cmp}) ? PADDLE_ACTIVE : PADDLE_IDLE;
            end
        end
    end

endmodule

// File: rtl/paddle_emulator.sv
// Paddle emulator top: follows the game's hsync/vsync, tracks the line
// about to be latched and drives both paddle lines so the game reads
// back exactly the per-frame target. Optional macro PADDLE_SLEW_EN
// rate-limits target changes inside each paddle_channel.
module paddle_emulator
    import paddle_pkg::*;
#(
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int VS_END_LINE = DEF_VS_END_LINE
) (
    input  logic             clk,
    input  logic             reset,
    paddle_emulator_if.slave bus
);

    localparam logic [8:0] LAST_LINE = 9'(V_TOTAL - 1);
    localparam logic [8:0] END_LINE  = 9'(VS_END_LINE);

    logic       hs_reg;
    logic       hs_prev;
    logic       vs_reg;
    logic       vs_prev;
    logic       hs_rise;
    logic       vs_rise;
    state_t     state;
    state_t     state_next;
    logic       load;
    logic       step;
    logic [8:0] line;
    logic [8:0] line_next;
    logic       synced;
    logic       frame_strobe;
    logic       hpaddle;
    logic       vpaddle;
    logic [7:0] target_x;
    logic [7:0] target_y;

    // Register both syncs and keep the previous sample; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_reg  <= 1'b1;
            hs_prev <= 1'b1;
            vs_reg  <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_reg  <= bus.hsync;
            hs_prev <= hs_reg;
            vs_reg  <= bus.vsync;
            vs_prev <= vs_reg;
        end
    end

    assign hs_rise = hs_reg & ~hs_prev;
    assign vs_rise = vs_reg & ~vs_prev;

    // State register for sync acquisition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_SYNC;
        else       state <= state_next;
    end

    // Next state and next line: a vsync end reloads the line (and wins
    // over a coincident hsync), otherwise hsync ends advance it in RUN.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        line_next  = line;
        if (vs_rise) begin
            state_next = RUN;
            load       = 1'b1;
            line_next  = END_LINE;
        end else if (hs_rise && (state == RUN)) begin
            step      = 1'b1;
            line_next = (line == LAST_LINE) ? 9'd0 : line + 9'd1;
        end
    end

    // Line counter, sync-seen flag and the one-cycle frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line         <= 9'd0;
            synced       <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= load;
            if (load) synced <= 1'b1;
            if (load || step) line <= line_next;
        end
    end

    paddle_channel u_chan_x (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .line_next (line_next),
        .pos       (bus.pos_x),
        .target    (target_x),
        .paddle    (hpaddle)
    );

    paddle_channel u_chan_y (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .line_next (line_next),
        .pos       (bus.pos_y),
        .target    (target_y),
        .paddle    (vpaddle)
    );

    assign bus.hpaddle      = hpaddle;
    assign bus.vpaddle      = vpaddle;
    assign bus.line         = line;
    assign bus.target_x     = target_x;
    assign bus.target_y     = target_y;
    assign bus.synced       = synced;
    assign bus.frame_strobe = frame_strobe;

endmodule

// File: tb/tb_paddle_emulator.sv
// Bench for paddle_emulator: a small sync generator (8 clocks per line,
// 262 lines, vsync ending between the hsync edges of lines 256 and 257)
// and a game-side latch model that records the last line whose hsync
// edge saw each paddle line low.
module tb_paddle_emulator;

    localparam int VT = 262;

    typedef struct {
        logic [7:0] px;
        logic [7:0] py;
        int         exp_lat_x;
        int         exp_lat_y;
        int         exp_cnt_x;
        int         exp_cnt_y;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    paddle_emulator_if bus();

    paddle_emulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   fs_total = 0;
    int   frame_fs;
    int   lat_x;
    int   lat_y;
    int   cnt_x;
    int   cnt_y;
    int   alias_hits;
    bit   check_line_en;
    bit   mid_en;
    logic [7:0] mid_val;
    vec_t vecs[4];
    int   exp_t[3];

    // Count clock cycles on which the frame pulse is high.
    always @(negedge clk) begin
        if (bus.frame_strobe === 1'b1) fs_total++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One video line: hsync low for 2 clocks, game samples the paddles at
    // the rising edge, vsync low from line 254 and released mid-line 256.
    task automatic applyStimulus(input int vpos);
        if (vpos == 254) bus.vsync = 1'b0;
        bus.hsync = 1'b0;
        wait_clk(2);
        if (bus.hpaddle == 1'b0) begin
            lat_x = vpos;
            cnt_x++;
            if (vpos >= 256) alias_hits++;
        end
        if (bus.vpaddle == 1'b0) begin
            lat_y = vpos;
            cnt_y++;
            if (vpos >= 256) alias_hits++;
        end
        if (mid_en && vpos == 120) bus.pos_x = mid_val;
        bus.hsync = 1'b1;
        wait_clk(3);
        if (vpos == 256) bus.vsync = 1'b1;
        wait_clk(3);
        if (check_line_en) checkOutput("line_track", 32'(bus.line), 32'((vpos + 1) % VT));
    endtask

    task automatic run_frame();
        int fs0;
        lat_x      = -1;
        lat_y      = -1;
        cnt_x      = 0;
        cnt_y      = 0;
        alias_hits = 0;
        fs0        = fs_total;
        for (int v = 0; v < VT; v++) applyStimulus(v);
        frame_fs = fs_total - fs0;
    endtask

    initial begin
        vecs[0] = '{px: 8'd0,   py: 8'd255, exp_lat_x: 0,   exp_lat_y: 255, exp_cnt_x: 1,   exp_cnt_y: 256};
        vecs[1] = '{px: 8'd255, py: 8'd0,   exp_lat_x: 255, exp_lat_y: 0,   exp_cnt_x: 256, exp_cnt_y: 1};
        vecs[2] = '{px: 8'd1,   py: 8'd254, exp_lat_x: 1,   exp_lat_y: 254, exp_cnt_x: 2,   exp_cnt_y: 255};
        vecs[3] = '{px: 8'd128, py: 8'd64,  exp_lat_x: 128, exp_lat_y: 64,  exp_cnt_x: 129, exp_cnt_y: 65};
`ifdef PADDLE_SLEW_EN
        exp_t = '{4, 8, 10};
`else
        exp_t = '{10, 10, 10};
`endif

        bus.hsync     = 1'b1;
        bus.vsync     = 1'b1;
        bus.pos_x     = 8'd0;
        bus.pos_y     = 8'd0;
        check_line_en = 1'b0;
        mid_en        = 1'b0;
        mid_val       = 8'd0;
        reset         = 1'b1;
        wait_clk(3);

        checkOutput("rst_hpaddle", 32'(bus.hpaddle), 32'd1);
        checkOutput("rst_vpaddle", 32'(bus.vpaddle), 32'd1);
        checkOutput("rst_line", 32'(bus.line), 32'd0);
        checkOutput("rst_target_x", 32'(bus.target_x), 32'd0);
        checkOutput("rst_target_y", 32'(bus.target_y), 32'd0);
        checkOutput("rst_synced", 32'(bus.synced), 32'd0);
        checkOutput("rst_strobe", 32'(bus.frame_strobe), 32'd0);

        reset = 1'b0;
        wait_clk(2);

        // hsync without vsync: emulator must stay idle and unsynced
        for (int i = 0; i < 300; i++) begin
            applyStimulus(i % 200);
            checkOutput("nosync_state",
                        32'({bus.hpaddle, bus.vpaddle, bus.synced, bus.frame_strobe, bus.line}),
                        32'({4'b1100, 9'd0}));
        end
        checkOutput("nosync_strobes", 32'(fs_total), 32'd0);

        // target sequence from 0 toward 10 (slew-limited when enabled)
        bus.pos_x = 8'd10;
        bus.pos_y = 8'd2;
        for (int f = 0; f < 3; f++) begin
            run_frame();
            if (f == 0) begin
                checkOutput("first_frame_cnt_x", 32'(cnt_x), 32'd0);
                checkOutput("first_synced", 32'(bus.synced), 32'd1);
            end
            checkOutput("seq_target_x", 32'(bus.target_x), 32'(exp_t[f]));
            checkOutput("seq_strobe", 32'(frame_fs), 32'd1);
        end
        checkOutput("seq_target_y", 32'(bus.target_y), 32'd2);

`ifndef PADDLE_SLEW_EN
        // main function: latched value and low-edge count per frame
        bus.pos_x = 8'd100;
        bus.pos_y = 8'd20;
        run_frame();
        run_frame();
        checkOutput("lat_x_100", 32'(lat_x), 32'd100);
        checkOutput("lat_y_20", 32'(lat_y), 32'd20);
        checkOutput("cnt_x_100", 32'(cnt_x), 32'd101);
        checkOutput("cnt_y_20", 32'(cnt_y), 32'd21);
        run_frame();
        checkOutput("lat_x_100_again", 32'(lat_x), 32'd100);

        for (int i = 0; i < 4; i++) begin
            bus.pos_x = vecs[i].px;
            bus.pos_y = vecs[i].py;
            run_frame();
            run_frame();
            checkOutput("vec_lat_x", 32'(lat_x), 32'(vecs[i].exp_lat_x));
            checkOutput("vec_lat_y", 32'(lat_y), 32'(vecs[i].exp_lat_y));
            checkOutput("vec_cnt_x", 32'(cnt_x), 32'(vecs[i].exp_cnt_x));
            checkOutput("vec_cnt_y", 32'(cnt_y), 32'(vecs[i].exp_cnt_y));
            checkOutput("vec_alias", 32'(alias_hits), 32'd0);
            checkOutput("vec_strobe", 32'(frame_fs), 32'd1);
            checkOutput("vec_target_x", 32'(bus.target_x), 32'(vecs[i].exp_lat_x));
            checkOutput("vec_target_y", 32'(bus.target_y), 32'(vecs[i].exp_lat_y));
        end

        // mid-frame change is deferred to the following frame
        bus.pos_x = 8'd60;
        run_frame();
        mid_en  = 1'b1;
        mid_val = 8'd200;
        run_frame();
        mid_en  = 1'b0;
        checkOutput("mid_lat_x_old", 32'(lat_x), 32'd60);
        checkOutput("mid_cnt_x_old", 32'(cnt_x), 32'd61);
        checkOutput("mid_strobe_a", 32'(frame_fs), 32'd1);
        run_frame();
        checkOutput("mid_lat_x_new", 32'(lat_x), 32'd200);
        checkOutput("mid_cnt_x_new", 32'(cnt_x), 32'd201);
        checkOutput("mid_strobe_b", 32'(frame_fs), 32'd1);
`endif

        // line tracking over a full frame, including the 261 -> 0 wrap
        check_line_en = 1'b1;
        run_frame();
        check_line_en = 1'b0;

        // coincident hsync and vsync ends: the reload to 257 wins
        for (int v = 0; v < 100; v++) applyStimulus(v);
        checkOutput("pre_coinc_line", 32'(bus.line), 32'd100);
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        wait_clk(2);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        wait_clk(6);
        checkOutput("coinc_line", 32'(bus.line), 32'd257);
        check_line_en = 1'b1;
        for (int v = 257; v < VT; v++) applyStimulus(v);
        check_line_en = 1'b0;

        // asynchronous reset in the middle of a frame
        for (int v = 0; v < 150; v++) applyStimulus(v);
        checkOutput("pre_reset_line", 32'(bus.line), 32'd150);
`ifdef PADDLE_SLEW_EN
        checkOutput("pre_reset_hpaddle", 32'(bus.hpaddle), 32'd1);
`else
        checkOutput("pre_reset_hpaddle", 32'(bus.hpaddle), 32'd0);
`endif
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_hpaddle", 32'(bus.hpaddle), 32'd1);
        checkOutput("mid_rst_vpaddle", 32'(bus.vpaddle), 32'd1);
        checkOutput("mid_rst_line", 32'(bus.line), 32'd0);
        checkOutput("mid_rst_synced", 32'(bus.synced), 32'd0);
        checkOutput("mid_rst_target_x", 32'(bus.target_x), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        for (int v = 0; v < 5; v++) begin
            applyStimulus(v);
            checkOutput("post_rst_state",
                        32'({bus.hpaddle, bus.vpaddle, bus.synced, bus.line}),
                        32'({3'b110, 9'd0}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
